// File: rtl/vga_timing_scaled.sv
// vga_timing_scaled
//   Parametrised VGA timing generator with a downscaled pixel-request stream.
//   Horizontal/vertical counters run on the pixel enable. The active region
//   produces (x, y) requests at 2^SCALE_LOG2 downscale. Syncs and the active
//   flag are delayed by SRC_LAT enables, so sync and colour reach the DAC
//   pins together with the colour returned by the pixel source.
//
// Optional build macro:
//   VGA_TEST_PATTERN_EN - colour comes from an internal 8-bar generator and
//                         i_red/i_green/i_blue are ignored.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_pix_en              pixel enable; all state advances only when high
//   o_req, o_x, o_y       active-pixel request and downscaled coordinates
//   i_red/green/blue      source colour, sampled SRC_LAT enables after o_req
//   o_red/green/blue      registered, blanked colour to the DAC
//   o_hsync, o_vsync      syncs with configurable polarity
//   o_line_start          one-enable pulse at h==0
//   o_frame_start         one-enable pulse at h==0, v==0
module vga_timing_scaled #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter int H_SYNC_POL = 1,
  parameter int V_SYNC_POL = 1,
  parameter int SCALE_LOG2 = 2,
  parameter int COLOR_W    = 2,
  parameter int SRC_LAT    = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_en,
  output logic               o_req,
  output logic [11:0]        o_x,
  output logic [11:0]        o_y,
  input  logic [COLOR_W-1:0] i_red,
  input  logic [COLOR_W-1:0] i_green,
  input  logic [COLOR_W-1:0] i_blue,
  output logic [COLOR_W-1:0] o_red,
  output logic [COLOR_W-1:0] o_green,
  output logic [COLOR_W-1:0] o_blue,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_line_start,
  output logic               o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        H_POL      = (H_SYNC_POL != 0);
  localparam logic        V_POL      = (V_SYNC_POL != 0);

  generate
    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
      $error("vga_timing_scaled: H_TOTAL/V_TOTAL must not exceed 4095");
    end
    if (SCALE_LOG2 < 0 || SCALE_LOG2 > 3) begin : g_bad_scale
      $error("vga_timing_scaled: SCALE_LOG2 must be 0..3");
    end
    if (SRC_LAT < 1 || SRC_LAT > 4) begin : g_bad_lat
      $error("vga_timing_scaled: SRC_LAT must be 1..4");
    end
  endgenerate

  logic [11:0]        h_q, h_d, v_q, v_d;
  logic               req_q, req_d;
  logic [11:0]        x_q, x_d, y_q, y_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [SRC_LAT-1:0] dly_act_q, dly_act_d;
  logic [SRC_LAT-1:0] dly_hs_q, dly_hs_d;
  logic [SRC_LAT-1:0] dly_vs_q, dly_vs_d;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;

  logic active, hs, vs;
  logic [COLOR_W-1:0] src_red, src_green, src_blue;

  assign active = (h_q < H_ACT_END) && (v_q < V_ACT_END);
  assign hs     = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
  assign vs     = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);

`ifdef VGA_TEST_PATTERN_EN
  // Bar index is the top three bits of the column range, delayed alongside
  // the active flag so the bars line up with the delayed blanking.
  localparam int BAR_MSB = $clog2(H_ACTIVE) - 1;

  generate
    if (H_ACTIVE < 8) begin : g_bad_bar
      $error("vga_timing_scaled: test pattern needs H_ACTIVE >= 8");
    end
  endgenerate

  logic [2:0] dly_bar_q [SRC_LAT];
  logic [2:0] dly_bar_d [SRC_LAT];
  logic       unused_src;

  assign unused_src = ^{i_red, i_green, i_blue};
  assign src_red    = {COLOR_W{dly_bar_q[SRC_LAT-1][2]}};
  assign src_green  = {COLOR_W{dly_bar_q[SRC_LAT-1][1]}};
  assign src_blue   = {COLOR_W{dly_bar_q[SRC_LAT-1][0]}};

  always_comb begin
    dly_bar_d = dly_bar_q;
    if (i_pix_en) begin
      dly_bar_d[0] = h_q[BAR_MSB -: 3];
      for (int i = 1; i < SRC_LAT; i++) begin
        dly_bar_d[i] = dly_bar_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dly_bar_q <= '{default: 3'b000};
    end else begin
      dly_bar_q <= dly_bar_d;
    end
  end
`else
  assign src_red   = i_red;
  assign src_green = i_green;
  assign src_blue  = i_blue;
`endif

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    req_d         = req_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    dly_act_d     = dly_act_q;
    dly_hs_d      = dly_hs_q;
    dly_vs_d      = dly_vs_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;

    if (i_pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 12'd1;
      end else begin
        h_d = h_q + 12'd1;
      end

      req_d         = active;
      x_d           = active ? (h_q >> SCALE_LOG2) : '0;
      y_d           = active ? (v_q >> SCALE_LOG2) : '0;
      line_start_d  = (h_q == '0);
      frame_start_d = (h_q == '0) && (v_q == '0);

      dly_act_d[0] = active;
      dly_hs_d[0]  = hs;
      dly_vs_d[0]  = vs;
      for (int i = 1; i < SRC_LAT; i++) begin
        dly_act_d[i] = dly_act_q[i-1];
        dly_hs_d[i]  = dly_hs_q[i-1];
        dly_vs_d[i]  = dly_vs_q[i-1];
      end

      // XNOR with the polarity passes the pulse through when active-high
      // and inverts it when active-low.
      hsync_d = dly_hs_q[SRC_LAT-1] ~^ H_POL;
      vsync_d = dly_vs_q[SRC_LAT-1] ~^ V_POL;

      red_d   = dly_act_q[SRC_LAT-1] ? src_red   : '0;
      green_d = dly_act_q[SRC_LAT-1] ? src_green : '0;
      blue_d  = dly_act_q[SRC_LAT-1] ? src_blue  : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      req_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      dly_act_q     <= '0;
      dly_hs_q      <= '0;
      dly_vs_q      <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      req_q         <= req_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      dly_act_q     <= dly_act_d;
      dly_hs_q      <= dly_hs_d;
      dly_vs_q      <= dly_vs_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign o_req         = req_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_red         = red_q;
  assign o_green       = green_q;
  assign o_blue        = blue_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_scaled.sv
// tb_vga_timing_scaled
//   Bench for vga_timing_scaled using a small 24x13 raster so several whole
//   frames fit in a short run. hsync is configured active-low and vsync
//   active-high so both polarity paths are exercised.
module tb_vga_timing_scaled;

  localparam int H_ACTIVE   = 16;
  localparam int H_FP       = 2;
  localparam int H_SYNC     = 3;
  localparam int H_BP       = 3;
  localparam int V_ACTIVE   = 8;
  localparam int V_FP       = 1;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 2;
  localparam int H_SYNC_POL = 0;
  localparam int V_SYNC_POL = 1;
  localparam int SCALE_LOG2 = 2;
  localparam int COLOR_W    = 2;
  localparam int SRC_LAT    = 2;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int F_TOTAL = H_TOTAL * V_TOTAL;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b1;
  logic               i_pix_en;
  logic               o_req;
  logic [11:0]        o_x, o_y;
  logic [COLOR_W-1:0] i_red, i_green, i_blue;
  logic [COLOR_W-1:0] o_red, o_green, o_blue;
  logic               o_hsync, o_vsync, o_line_start, o_frame_start;

  int n_checks;
  int n_errors;
  bit cmp_en;

  // Enables seen since the last reset, and the colour present at the latest one.
  int                 en_count;
  logic [COLOR_W-1:0] smp_r, smp_g, smp_b;

  vga_timing_scaled #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_SYNC_POL(H_SYNC_POL), .V_SYNC_POL(V_SYNC_POL),
    .SCALE_LOG2(SCALE_LOG2), .COLOR_W(COLOR_W), .SRC_LAT(SRC_LAT)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_pix_en(i_pix_en),
    .o_req(o_req),
    .o_x(o_x),
    .o_y(o_y),
    .i_red(i_red),
    .i_green(i_green),
    .i_blue(i_blue),
    .o_red(o_red),
    .o_green(o_green),
    .o_blue(o_blue),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_line_start(o_line_start),
    .o_frame_start(o_frame_start)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_count = 0;
    end else if (i_pix_en) begin
      en_count = en_count + 1;
      smp_r = i_red;
      smp_g = i_green;
      smp_b = i_blue;
    end
  end

  task automatic applyStimulus(input logic en, input logic [COLOR_W-1:0] r,
                               input logic [COLOR_W-1:0] g, input logic [COLOR_W-1:0] b);
    i_pix_en = en;
    i_red    = r;
    i_green  = g;
    i_blue   = b;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, actual, expected);
    end
  endtask

  // Raster position p (in enables since reset) -> decoded flags. p < 0 means
  // the position has not been reached yet, which looks like blanking.
  function automatic void pos_decode(input int p, output bit act, output bit hs,
                                     output bit vs, output int h, output int v);
    act = 0; hs = 0; vs = 0; h = 0; v = 0;
    if (p >= 0) begin
      h   = p % H_TOTAL;
      v   = (p / H_TOTAL) % V_TOTAL;
      act = (h < H_ACTIVE) && (v < V_ACTIVE);
      hs  = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
      vs  = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
    end
  endfunction

  function automatic logic [63:0] model_outputs();
    bit act0, hs0, vs0, act1, hs1, vs1;
    int h0, v0, h1, v1;
    logic [11:0] ex, ey;
    logic [COLOR_W-1:0] er, eg, eb;
    logic ehs, evs, els, efs;
    pos_decode(en_count - 1, act0, hs0, vs0, h0, v0);
    pos_decode(en_count - 1 - SRC_LAT, act1, hs1, vs1, h1, v1);
    ex  = act0 ? 12'(h0 >> SCALE_LOG2) : 12'd0;
    ey  = act0 ? 12'(v0 >> SCALE_LOG2) : 12'd0;
    els = (en_count > 0) && (h0 == 0);
    efs = els && (v0 == 0);
    ehs = (H_SYNC_POL != 0) ? hs1 : !hs1;
    evs = (V_SYNC_POL != 0) ? vs1 : !vs1;
    er = '0; eg = '0; eb = '0;
    if (act1) begin
`ifdef VGA_TEST_PATTERN_EN
      int bar;
      bar = (h1 >> ($clog2(H_ACTIVE) - 3)) & 7;
      er = ((bar & 4) != 0) ? '1 : '0;
      eg = ((bar & 2) != 0) ? '1 : '0;
      eb = ((bar & 1) != 0) ? '1 : '0;
`else
      er = smp_r; eg = smp_g; eb = smp_b;
`endif
    end
    return {29'd0, act0, ex, ey, er, eg, eb, ehs, evs, els, efs};
  endfunction

  always @(negedge i_clk) begin
    if (cmp_en) begin
      checkOutput("cycle_outputs",
                  {29'd0, o_req, o_x, o_y, o_red, o_green, o_blue,
                   o_hsync, o_vsync, o_line_start, o_frame_start},
                  model_outputs());
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_fs, second_fs, ls0, ls1, n_ls;
    int req_cnt, hs_low, vs_hi, red_full, max_x, max_y;
    int exp_red_full;
    bit hit, found;

    n_checks = 0; n_errors = 0; cmp_en = 0;
    first_fs = -1; second_fs = -1; ls0 = -1; ls1 = -1; n_ls = 0;
    req_cnt = 0; hs_low = 0; vs_hi = 0; red_full = 0; max_x = 0; max_y = 0;
    applyStimulus(1'b0, '0, '0, '0);
    #1 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);

    // Reset levels: active-low hsync idles high, active-high vsync idles low.
    checkOutput("rst_hsync", o_hsync, 1);
    checkOutput("rst_vsync", o_vsync, 0);
    checkOutput("rst_req", o_req, 0);
    checkOutput("rst_frame_start", o_frame_start, 0);
    checkOutput("rst_red", o_red, 0);
    cmp_en = 1;

    // Continuous enable, constant full-scale red.
    applyStimulus(1'b1, 2'd3, 2'($urandom), 2'($urandom));
    i_rst_n = 1'b1;
    for (int c = 1; c <= 340; c++) begin
      @(negedge i_clk);
      if (o_frame_start) begin
        if (first_fs < 0) first_fs = c;
        else if (second_fs < 0) second_fs = c;
      end
      if (o_line_start) begin
        if (n_ls == 0) ls0 = c;
        else if (n_ls == 1) ls1 = c;
        n_ls++;
      end
      if (c >= 1 && c <= F_TOTAL) begin
        req_cnt += int'(o_req);
        if (int'(o_x) > max_x) max_x = int'(o_x);
        if (int'(o_y) > max_y) max_y = int'(o_y);
      end
      if (c >= 1 + SRC_LAT && c <= F_TOTAL + SRC_LAT) begin
        hs_low   += int'(!o_hsync);
        vs_hi    += int'(o_vsync);
        red_full += int'(o_red == 2'd3);
      end
      applyStimulus(1'b1, 2'd3, 2'($urandom), 2'($urandom));
    end
`ifdef VGA_TEST_PATTERN_EN
    exp_red_full = 64;
`else
    exp_red_full = 128;
`endif
    checkOutput("first_frame_start", 64'(first_fs), 1);
    checkOutput("frame_period", 64'(second_fs - first_fs), 312);
    checkOutput("second_line_start", 64'(ls1), 25);
    checkOutput("line_period", 64'(ls1 - ls0), 24);
    checkOutput("req_per_frame", 64'(req_cnt), 128);
    checkOutput("hsync_low_per_frame", 64'(hs_low), 39);
    checkOutput("vsync_high_per_frame", 64'(vs_hi), 48);
    checkOutput("red_full_per_frame", 64'(red_full), 64'(exp_red_full));
    checkOutput("max_x", 64'(max_x), 3);
    checkOutput("max_y", 64'(max_y), 1);

    // Sparse then half-rate random enables with random colour.
    for (int c = 0; c < 4000; c++) begin
      @(negedge i_clk);
      applyStimulus((c < 2000) ? ($urandom_range(3) == 0) : 1'($urandom_range(1)),
                    2'($urandom), 2'($urandom), 2'($urandom));
    end

    // Mid-frame asynchronous reset at h=10, v=5.
    hit = 0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      @(negedge i_clk);
      applyStimulus(1'b1, 2'($urandom), 2'($urandom), 2'($urandom));
      if (en_count % F_TOTAL == 5 * H_TOTAL + 10) hit = 1;
    end
    checkOutput("reached_h10_v5", 64'(hit), 1);
    #2 i_rst_n = 1'b0;
    #1 checkOutput("async_reset_outputs",
                   {29'd0, o_req, o_x, o_y, o_red, o_green, o_blue,
                    o_hsync, o_vsync, o_line_start, o_frame_start},
                   64'h8);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    found = 0;
    for (int k = 0; k < 2 && !found; k++) begin
      @(negedge i_clk);
      if (o_frame_start) found = 1;
    end
    checkOutput("frame_start_after_reset", 64'(found), 1);

    for (int c = 0; c < 300; c++) begin
      @(negedge i_clk);
      applyStimulus(1'($urandom_range(1)), 2'($urandom), 2'($urandom), 2'($urandom));
    end

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
